// File: rtl/pm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pm_mem_arbiter
// Brief    : Single-port memory arbiter for HPS download, LCD fetch and CPU,
//            one access in flight, fixed priority dl > lcd > cpu.
//            Optional CPU starvation guard: define PM_ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pm_mem_arbiter #(
   parameter int ADDR_W       = 21,
   parameter int RD_LATENCY   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              dl_req,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [7:0]        dl_data,
   output logic              dl_ack,
   input  logic              lcd_req,
   input  logic [ADDR_W-1:0] lcd_addr,
   output logic [7:0]        lcd_rdata,
   output logic              lcd_ack,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWN_DL  = 2'd0,
      OWN_LCD = 2'd1,
      OWN_CPU = 2'd2
   } owner_t;

   localparam int              LAT_W    = 4;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

   if (RD_LATENCY < 1 || RD_LATENCY > 15 || STARVE_LIMIT < 1) begin : g_param_check
      $error("pm_mem_arbiter: RD_LATENCY must be 1..15 and STARVE_LIMIT >= 1");
   end

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              rd_q, rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [7:0]        lcd_rdata_q, lcd_rdata_d;
   logic [7:0]        cpu_rdata_q, cpu_rdata_d;

   logic              force_cpu;
   logic              grant_dl;
   logic              grant_lcd;
   logic              grant_cpu;

`ifdef PM_ARB_STARVE_GUARD_EN
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic [STARVE_W-1:0] starve_q, starve_d;

   // Once LCD has won STARVE_LIMIT times over a waiting CPU, CPU jumps LCD.
   assign force_cpu = cpu_req && (starve_q == STARVE_W'(STARVE_LIMIT));

   always_comb begin
      starve_d = starve_q;
      if (state_q == S_IDLE) begin
         if (!cpu_req || grant_cpu) begin
            starve_d = '0;
         end else if (grant_lcd) begin
            starve_d = starve_q + STARVE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign force_cpu = 1'b0;
`endif

   assign grant_dl  = dl_req;
   assign grant_lcd = !dl_req && lcd_req && !force_cpu;
   assign grant_cpu = !dl_req && cpu_req && (force_cpu || !lcd_req);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rd_d        = rd_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      lat_d       = lat_q;
      lcd_rdata_d = lcd_rdata_q;
      cpu_rdata_d = cpu_rdata_q;

      unique case (state_q)
         S_IDLE: begin
            if (grant_dl) begin
               owner_d = OWN_DL;
               rd_d    = 1'b0;
               addr_d  = dl_addr;
               wdata_d = dl_data;
               state_d = S_ISSUE;
            end else if (grant_lcd) begin
               owner_d = OWN_LCD;
               rd_d    = 1'b1;
               addr_d  = lcd_addr;
               state_d = S_ISSUE;
            end else if (grant_cpu) begin
               owner_d = OWN_CPU;
               rd_d    = !cpu_we;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (rd_q) begin
               lat_d   = LAT_LOAD;
               state_d = S_WAIT;
            end else begin
               state_d = S_DONE;
            end
         end
         S_WAIT: begin
            // Counter reaching zero marks the cycle in which mem_rdata is valid.
            if (lat_q == '0) begin
               state_d = S_DONE;
               if (owner_q == OWN_LCD) begin
                  lcd_rdata_d = mem_rdata;
               end else if (owner_q == OWN_CPU) begin
                  cpu_rdata_d = mem_rdata;
               end
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_DL;
         rd_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         lat_q       <= '0;
         lcd_rdata_q <= '0;
         cpu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rd_q        <= rd_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         lat_q       <= lat_d;
         lcd_rdata_q <= lcd_rdata_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   // Strobes and acks decode straight from state so reset silences them at once.
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = (state_q == S_ISSUE) && !rd_q;
   assign mem_re    = (state_q == S_ISSUE) && rd_q;
   assign busy      = (state_q != S_IDLE);
   assign dl_ack    = (state_q == S_DONE) && (owner_q == OWN_DL);
   assign lcd_ack   = (state_q == S_DONE) && (owner_q == OWN_LCD);
   assign cpu_ack   = (state_q == S_DONE) && (owner_q == OWN_CPU);
   assign lcd_rdata = lcd_rdata_q;
   assign cpu_rdata = cpu_rdata_q;

endmodule
`default_nettype wire
